// File: rtl/pc_gen_btb.sv
// Fetch-stage next-PC generator with stall, trap/redirect priority and a direct-mapped BTB.
// pc is registered (1-cycle redirect latency); stall holds pc, but trap/redirect and BTB training still act.
module pc_gen_btb #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_hit,
    output logic [XLEN-1:0] pred_target,
    output logic [XLEN-1:0] pc_plus4
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
    logic [XLEN-3:0]        tgt_q [BTB_ENTRIES];
    logic [XLEN-3:0]        tgt_d [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             unused_bits;

    assign lk_idx      = pc_q[IDX_W+1:2];
    assign lk_tag      = pc_q[XLEN-1:IDX_W+2];
    assign up_idx      = upd_pc[IDX_W+1:2];
    assign up_tag      = upd_pc[XLEN-1:IDX_W+2];
    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    // Lookup reads pre-edge contents, so a same-cycle update is seen only from the next cycle.
    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_target = pred_hit ? {tgt_q[lk_idx], 2'b00} : '0;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc          = pc_q;

    always_comb begin
        pc_d = pc_plus4;
        if (trap_valid) begin
            pc_d = trap_target;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_hit) begin
            pc_d = pred_target;
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (upd_valid) begin
            if (upd_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target[XLEN-1:2];
            end else if (valid_q[up_idx] && (tag_q[up_idx] == up_tag)) begin
                valid_d[up_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Tag/target storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: directed scenarios followed by randomized traffic against a word-address BTB model.
module tb_pc_gen_btb;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] pc, pred_target, pc_plus4;
    logic        pred_hit;

    int checks = 0;
    int errors = 0;

    // Reference model: each slot remembers the word address of the branch it holds.
    bit          m_valid [N];
    logic [31:0] m_bpc   [N];
    logic [31:0] m_tgt   [N];
    logic [31:0] exp_pc;

    pc_gen_btb dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .pc(pc), .pred_hit(pred_hit), .pred_target(pred_target), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_bpc[slot(a)][31:2] == a[31:2]);
    endfunction

    // One clock: apply inputs, check lookup outputs, advance model, check registered pc.
    task automatic step(input bit st, input bit rv, input logic [31:0] rt,
                        input bit tv, input logic [31:0] tt,
                        input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
        logic [31:0] nxt;
        bit          h;
        logic [31:0] ptg;
        stall = st; redirect_valid = rv; redirect_target = rt;
        trap_valid = tv; trap_target = tt;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        #1;
        h   = m_hit(exp_pc);
        ptg = h ? {m_tgt[slot(exp_pc)][31:2], 2'b00} : 32'h0;
        chk("pc", pc, exp_pc);
        chk("pred_hit", {31'b0, pred_hit}, {31'b0, h});
        chk("pred_target", pred_target, ptg);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        if (tv)      nxt = tt;
        else if (rv) nxt = rt;
        else if (st) nxt = exp_pc;
        else if (h)  nxt = ptg;
        else         nxt = exp_pc + 32'd4;
        if (uv) begin
            if (ut) begin
                m_valid[slot(upc)] = 1'b1;
                m_bpc[slot(upc)]   = upc;
                m_tgt[slot(upc)]   = utg;
            end else if (m_hit(upc)) begin
                m_valid[slot(upc)] = 1'b0;
            end
        end
        @(posedge clk); #1;
        exp_pc = nxt;
        chk("pc_next", pc, exp_pc);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input logic [31:0] a);
        step(0, 1, a, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] a, input bit tk, input logic [31:0] t);
        step(0, 0, 0, 0, 0, 1, a, tk, t);
    endtask

    // Reset asserted mid-cycle; an update pending during reset must be lost.
    task automatic do_reset();
        upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1; upd_target = 32'h80;
        rstn = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_hit", {31'b0, pred_hit}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_bpc[i] = '0; m_tgt[i] = '0;
        end
        exp_pc = 32'h0;
        #2;
        do_reset();

        // Sequential fetch 0,4,8,C then stalls and a stalled redirect.
        repeat (4) idle();
        chk("seq_pc", pc, 32'h10);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_hold", pc, 32'h10);
        step(1, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        chk("stall_redirect", pc, 32'h200);
        step(1, 1, 32'h200, 1, 32'h1C0, 0, 0, 0, 0);
        chk("trap_prio", pc, 32'h1C0);

        // Train 0x8 -> 0x40 and refetch from 0.
        train(32'h8, 1, 32'h40);
        go(32'h0);
        idle(); idle();
        chk("hit_at_8", {31'b0, pred_hit}, 32'h1);
        idle();
        chk("pred_jump", pc, 32'h40);

        // Not-taken clears the entry.
        train(32'h8, 0, 32'h0);
        go(32'h8);
        idle();
        chk("cleared", pc, 32'hC);

        // Alias 0x28 trained while at 0x8: this cycle still uses the old entry.
        train(32'h8, 1, 32'h40);
        go(32'h8);
        step(0, 0, 0, 0, 0, 1, 32'h28, 1, 32'h100);
        chk("alias_old", pc, 32'h40);
        go(32'h8);
        chk("alias_miss", {31'b0, pred_hit}, 32'h0);
        idle();

        // Not-taken for an alias leaves the resident entry alone.
        train(32'h8, 1, 32'h40);
        train(32'h28, 0, 32'h0);
        go(32'h8);
        chk("alias_keep", {31'b0, pred_hit}, 32'h1);
        idle();

        // Wrap-around.
        go(32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        idle();
        chk("wrap_pc", pc, 32'h0);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rt, tt, upc, utg;
            rt  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3) == 0 ? 1 : 0)};
            tt  = {20'h0, 4'($urandom), 6'($urandom), 2'b00};
            upc = ($urandom_range(0, 3) == 0) ? {$urandom} : {24'h0, 6'($urandom), 2'b00};
            utg = {24'h0, 8'($urandom)};
            if (n == 200) begin
                do_reset();
                chk("post_rst_pc", pc, 32'h0);
            end
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rt,
                 $urandom_range(0, 19) == 0, tt,
                 $urandom_range(0, 9) < 4, upc, $urandom_range(0, 2) != 0, utg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
